// File: rtl/mem_stream_loader.sv
// mem_stream_loader: byte-serial framed loader that writes
// little-endian 32-bit words into the split inst/data memory.
module mem_stream_loader #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [7:0]  CMD_INST  = 8'h01,
  parameter logic [7:0]  CMD_DATA  = 8'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_wsel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written
);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        sel;
  logic [31:0] base;
  logic [31:0] word;
  logic [15:0] count;
  logic [15:0] idx;
  logic [2:0]  bcnt;

  logic        fire;
  logic        cmd_ok;
  logic        last_hdr;
  logic        last_byte;
  logic        last_word;
  logic        zero_cnt;
  logic [31:0] waddr;
  logic [31:0] wnext;

  assign fire      = in_valid & in_ready;
  assign cmd_ok    = (in_data == CMD_INST) ||
                     (in_data == CMD_DATA);
  assign last_hdr  = bcnt == 3'd5;
  assign last_byte = bcnt == 3'd3;
  assign zero_cnt  = {in_data, count[7:0]} == 16'd0;
  assign last_word = (idx + 16'd1) == count;
  assign waddr     = base + {16'd0, idx};
  assign wnext     = {in_data, word[31:8]};

  // State register; busy is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= state_nxt != IDLE;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (fire && cmd_ok)
          state_nxt = HDR;
      HDR:
        if (fire && last_hdr)
          state_nxt = zero_cnt ? IDLE : DATA;
      DATA:
        if (fire && last_byte)
          state_nxt = WRITE;
      WRITE:
        state_nxt = last_word ? IDLE : DATA;
    endcase
  end

  // Only in_ready is decoded straight from state
  always_comb begin
    in_ready = state != WRITE;
  end

  // Framing registers and registered memory-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel           <= 1'b0;
      base          <= 32'd0;
      count         <= 16'd0;
      idx           <= 16'd0;
      word          <= 32'd0;
      bcnt          <= 3'd0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      mem_wsel      <= 2'd2;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= 16'd0;
    end else begin
      done     <= 1'b0;
      mem_wsel <= 2'd2;
      unique case (state)
        IDLE: begin
          if (fire) begin
            if (cmd_ok) begin
              sel           <= in_data == CMD_DATA;
              err           <= 1'b0;
              words_written <= 16'd0;
              bcnt          <= 3'd0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (fire) begin
            unique case (bcnt)
              3'd0:    base[7:0]    <= in_data;
              3'd1:    base[15:8]   <= in_data;
              3'd2:    base[23:16]  <= in_data;
              3'd3:    base[31:24]  <= in_data;
              3'd4:    count[7:0]   <= in_data;
              default: count[15:8]  <= in_data;
            endcase
            bcnt <= bcnt + 3'd1;
            if (last_hdr) begin
              bcnt <= 3'd0;
              idx  <= 16'd0;
              done <= zero_cnt;
            end
          end
        end
        DATA: begin
          if (fire) begin
            word <= wnext;
            bcnt <= last_byte ? 3'd0 : bcnt + 3'd1;
            if (last_byte) begin
              mem_addr  <= waddr;
              mem_wdata <= wnext;
              if (waddr < 32'(MEM_WORDS))
                mem_wsel <= {1'b0, sel};
              else
                err <= 1'b1;
            end
          end
        end
        WRITE: begin
          words_written <= words_written + 16'd1;
          idx           <= idx + 16'd1;
          done          <= last_word;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Upstream write master for the split instruction/data memory (mem_module).
- Receives a byte-serial load stream over a valid/ready handshake and parses framed load commands.
- Assembles little-endian 32-bit words and issues one-cycle writes on the memory's addr/data_in/write_select interface.
- Used for boot-time program/data loading. mem_module is a peer; this block holds no storage beyond framing registers.

Parameters:
- MEM_WORDS, 4096, depth of each memory in 32-bit words; writes at word address >= MEM_WORDS are suppressed.
- CMD_INST, 8'h01, command byte selecting instruction memory (write_select 0).
- CMD_DATA, 8'h02, command byte selecting data memory (write_select 1).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  block can accept a byte this cycle.
- mem_addr  output  32  word address to memory addr.
- mem_wdata  output  32  write data to memory data_in.
- mem_wsel  output  2  to memory write_select: 0 = inst, 1 = data, 2 = none.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse at end of frame.
- err  output  1  sticky error flag.
- words_written  output  16  count of words processed in the current/last frame.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Handshake: a byte transfers at a rising edge with in_valid && in_ready. in_ready = 1 in every state except WRITE.
- Frame format: cmd byte; base address (4 bytes, little-endian word address); count (2 bytes, little-endian, words); then count×4 data bytes, each word little-endian.

State machine (states IDLE, HDR, DATA, WRITE):
- IDLE:
  - On cmd == CMD_INST or CMD_DATA: latch sel (0/1), clear err, clear words_written, go to HDR.
  - On any other cmd byte: set err, stay in IDLE (byte consumed).
- HDR: collect 6 bytes into base[31:0] and count[15:0].
  - On the 6th byte, if count == 0: pulse done in the next cycle and go to IDLE.
  - Otherwise: idx = 0, go to DATA.
- DATA: collect 4 bytes into word (first byte goes to bits [7:0]). On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_addr = base + idx (modulo 2^32); mem_wdata = word.
  - mem_wsel = sel if mem_addr < MEM_WORDS; otherwise mem_wsel = 2 and err is set.
  - words_written increments at the end of this cycle, including suppressed writes.
  - If idx + 1 == count: go to IDLE, pulse done in the next cycle.
  - Otherwise: idx++, go to DATA.

Output rules:
- mem_wsel = 2 in every cycle outside WRITE.
- mem_addr and mem_wdata hold their last values outside WRITE.
- All outputs are registered or state-decoded; in_ready is the only state-decoded output.

Latency:
- WRITE occupies the cycle immediately after the edge that accepts the 4th data byte.
- The memory captures the write at the end of that cycle.
- Minimum frame time is 7 + 5×count cycles.

Boundary conditions:
- Bubbles (in_valid = 0) in any state stall the block with no state change.
- Base-address overflow wraps modulo 2^32; wrapped addresses are still range-checked against MEM_WORDS.
- err sets only on a bad cmd byte or an out-of-range write. It clears only on a valid cmd byte or on reset.

Reset values and mid-frame reset:
- On reset, the state is forced to IDLE.
- Reset values: in_ready = 1, mem_addr = 0, mem_wdata = 0, mem_wsel = 2, busy = 0, done = 0, err = 0, words_written = 0.
- A partial frame in progress at reset is discarded and no write is issued, even if reset lands in WRITE.

Test Plan:
- Inst load: stream 01, 10 00 00 00, 02 00, then 78 56 34 12, EF BE AD DE.
  - Required: two WRITE cycles, (mem_wsel 0, addr 0x10, wdata 0x12345678) and (mem_wsel 0, addr 0x11, wdata 0xDEADBEEF).
  - Then done pulse, words_written = 2, and inst_mem[0x10..0x11] read back correct.
- Data load with in_valid toggling every other cycle: cmd 02, base 0x20, count 1, word 0xCAFEF00D.
  - Required: single write with mem_wsel 1 at addr 0x20; in_ready = 0 only during WRITE; no lost or duplicated bytes.
- Range check: cmd 01, base 0xFFF, count 2.
  - Required: addr 0xFFF written with mem_wsel 0; addr 0x1000 drives mem_wsel 2; err = 1; done pulses; words_written = 2.
- Bad command and zero count: byte 0x7F.
  - Required: err = 1, busy stays 0.
  - Then frame 02, base 0, count 0: err clears on the 02 byte, done pulses with no write, mem_wsel stays 2.
- Reset mid-frame: drop rst_n after 2 data bytes of a count-1 frame.
  - Required: immediate IDLE, in_ready = 1, mem_wsel = 2, no write.
  - A subsequent full frame loads correctly.
